// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;
    localparam int DIV_WIDTH = 32;
    localparam int CNT_W     = $clog2(DIV_WIDTH);

    // MIPS leaves LO undefined on divide-by-zero; all ones makes it easy to spot.
    localparam logic [DIV_WIDTH-1:0] DZ_QUOT = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_e;
endpackage

// File: rtl/div_step.sv
// One radix-2 restoring step: shift {r, q} left, then trial-subtract the divisor.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] r_i,
    input  logic [WIDTH-1:0] q_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] r_o,
    output logic [WIDTH-1:0] q_o
);
    logic [WIDTH:0] r_sh;
    logic           fits;

    // The shifted remainder can exceed WIDTH bits when the divisor is above 2^(WIDTH-1).
    assign r_sh = {r_i, q_i[WIDTH-1]};
    assign fits = (r_sh >= {1'b0, d_i});
    assign r_o  = fits ? WIDTH'(r_sh - {1'b0, d_i}) : r_sh[WIDTH-1:0];
    assign q_o  = {q_i[WIDTH-2:0], fits};
endmodule

// File: rtl/seq_div.sv
// Multi-cycle DIV/DIVU unit: magnitude restoring loop plus sign fix-up, busy/done handshake.
//   state | meaning
//   IDLE  | waiting for start
//   CALC  | one quotient bit per cycle, WIDTH cycles
//   FIX   | apply signs / divide-by-zero result, load outputs
//   DONE  | done pulse; start here is accepted like IDLE
module seq_div
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             of_flag,
    output logic             dz_flag
);
    localparam int               CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]    LAST = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

    div_state_e       state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] r_q, q_q, d_q;
    logic [WIDTH-1:0] r_d, q_d;
    logic             neg_q_q, neg_r_q, of_pend_q, dz_pend_q;
    logic             busy_q, done_q, of_q, dz_q;
    logic [WIDTH-1:0] quot_q, rem_q;

    logic             b_zero, a_neg, b_neg;
    logic [WIDTH-1:0] a_abs, b_abs;

    assign b_zero = (b == '0);
    assign a_neg  = is_signed & a[WIDTH-1];
    assign b_neg  = is_signed & b[WIDTH-1];
    assign a_abs  = a_neg ? -a : a;
    assign b_abs  = b_neg ? -b : b;

    div_step #(.WIDTH(WIDTH)) u_step (
        .r_i(r_q),
        .q_i(q_q),
        .d_i(d_q),
        .r_o(r_d),
        .q_o(q_d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            r_q       <= '0;
            q_q       <= '0;
            d_q       <= '0;
            neg_q_q   <= 1'b0;
            neg_r_q   <= 1'b0;
            of_pend_q <= 1'b0;
            dz_pend_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            quot_q    <= '0;
            rem_q     <= '0;
            of_q      <= 1'b0;
            dz_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        busy_q    <= 1'b1;
                        of_q      <= 1'b0;
                        dz_q      <= 1'b0;
                        cnt_q     <= '0;
                        r_q       <= '0;
                        d_q       <= b_abs;
                        // On divide-by-zero q_q parks the raw dividend for the HI result.
                        q_q       <= b_zero ? a : a_abs;
                        neg_q_q   <= ~b_zero & (a_neg ^ b_neg);
                        neg_r_q   <= ~b_zero & a_neg;
                        of_pend_q <= is_signed & (a == SMIN) & (b == '1);
                        dz_pend_q <= b_zero;
                        state_q   <= b_zero ? FIX : CALC;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                CALC: begin
                    r_q <= r_d;
                    q_q <= q_d;
                    if (cnt_q == LAST) begin
                        state_q <= FIX;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                FIX: begin
                    if (dz_pend_q) begin
                        quot_q <= WIDTH'(DZ_QUOT);
                        rem_q  <= q_q;
                        dz_q   <= 1'b1;
                        of_q   <= 1'b0;
                    end else begin
                        quot_q <= neg_q_q ? -q_q : q_q;
                        rem_q  <= neg_r_q ? -r_q : r_q;
                        of_q   <= of_pend_q;
                    end
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= DONE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign quotient  = quot_q;
    assign remainder = rem_q;
    assign of_flag   = of_q;
    assign dz_flag   = dz_q;
endmodule

// File: doc/seq_div.md
# seq_div

Multi-cycle 32-bit integer divider for the micro MIPS execute stage, handling DIV/DIVU and writing HI/LO. It is the inverse companion of the combinational Booth multiplier `boot_prod`. It takes a dividend and divisor on a start pulse and runs a radix-2 restoring loop, one quotient bit per clock. It returns quotient, remainder, overflow and divide-by-zero flags with a busy/done handshake so the pipeline can stall.

## Interface
Parameters:
- `WIDTH`, 32: operand and result width. Loop count equals `WIDTH`.

Ports:
- `clk` in 1: single clock. All state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle request. Sampled only in IDLE.
- `is_signed` in 1: 1 selects DIV (two's complement), 0 selects DIVU. Sampled with `start`.
- `a` in WIDTH: dividend. Sampled with `start`.
- `b` in WIDTH: divisor. Sampled with `start`.
- `busy` out 1: high from the edge that accepts `start` until the edge that raises `done`.
- `done` out 1: one-cycle pulse. Results are valid from this cycle.
- `quotient` out WIDTH: LO value. Held until the next accepted `start`.
- `remainder` out WIDTH: HI value. Held until the next accepted `start`.
- `of_flag` out 1: signed overflow, i.e. `a`=0x80000000, `b`=0xFFFFFFFF, `is_signed`=1.
- `dz_flag` out 1: divisor was zero.

## Operation
- States are IDLE, CALC, FIX and DONE.
- **IDLE**
  - `start`=1 and `b`≠0: latch operands into internal registers.
  - Signed mode uses |a| and |b| and records `neg_q`=a[31]^b[31] and `neg_r`=a[31].
  - Clear the partial remainder `r` and the counter. Go to CALC.
  - `start`=1 and `b`=0: go to FIX with `dz_flag` pending.
- **CALC**, once per cycle, exactly WIDTH cycles:
  - Shift {r, q} left by 1.
  - Trial `t` = r − |b| on WIDTH+1 bits.
  - If `t` ≥ 0: `r` ← t[WIDTH-1:0] and q[0] ← 1. Otherwise q[0] ← 0.
  - When the counter reaches WIDTH−1, go to FIX.
- **FIX**
  - Apply signs: quotient ← `neg_q` ? −q : q. Remainder ← `neg_r` ? −r : r.
  - Compute `of_flag`.
  - Divide by zero: quotient ← all ones, remainder ← `a`, `dz_flag`←1, `of_flag`←0.
  - Go to DONE.
- **DONE**
  - `done`=1 and `busy`=0.
  - Next state is IDLE. A `start` in this cycle is accepted as if in IDLE.
- Overflow case, −2^31 / −1: the loop gives 0x80000000. The result is quotient 0x80000000, remainder 0, `of_flag`=1. No trap is raised here.
- Remainder sign always equals dividend sign (MIPS truncating division).
- Unsigned mode: `neg_q`=`neg_r`=0 and `of_flag`=0.
- `start` during CALC or FIX is ignored. No queueing.
- Outputs are registered and change only in FIX. Flags are cleared on an accepted `start`.

## Timing
- Reset values: state=IDLE, `busy`=0, `done`=0, `quotient`=0, `remainder`=0, `of_flag`=0, `dz_flag`=0, counter=0.
- Normal latency, with `start` sampled at edge E:
  - `busy`=1 after E.
  - CALC runs over edges E+1 to E+WIDTH.
  - FIX is at E+WIDTH+1.
  - `done`=1 in the cycle after edge E+WIDTH+1, i.e. 34 cycles after E for WIDTH=32.
- Divide-by-zero latency: FIX at E+1, `done` in the cycle after E+1.
- Back-to-back: `start` in the `done` cycle is accepted. There is no dead cycle.
- Reset mid-operation: all state returns to reset values immediately, with no `done` pulse. Held results are lost.

## Structure
- Package `div_pkg` holds:
  - the state enum (IDLE, CALC, FIX, DONE) with a 2-bit encoding;
  - `DIV_WIDTH`=32 and the counter width;
  - the divide-by-zero quotient constant (all ones).
- One natural sub-module, `div_step`: combinational shift-and-trial-subtract.
  - Inputs: r, q, |b|.
  - Outputs: next r, next q.
  - Can be unit-tested alone.
- The top holds the FSM, counter, sign fix-up and output registers.

## Test plan
- Reset, then `a`=0, `b`=3, signed → `done` at cycle 34, quotient 0, remainder 0, flags 0.
- `a`=4388, `b`=−137, signed → quotient −32 (0xFFFFFFE0), remainder 4, `busy` high for 33 cycles.
- `a`=0xFFFFFFF9, `b`=2:
  - signed → quotient −3, remainder −1;
  - unsigned → quotient 0x7FFFFFFC, remainder 1.
- `a`=0x80000000, `b`=0xFFFFFFFF, signed → quotient 0x80000000, remainder 0, `of_flag`=1.
- `a`=17, `b`=0 → `done` 2 cycles after start, quotient 0xFFFFFFFF, remainder 17, `dz_flag`=1.
- Assert `rst` at CALC cycle 10, then start `a`=100, `b`=7 → no stale `done`, outputs read 0 after reset, then quotient 14, remainder 2. A `start` issued in the `done` cycle is accepted.
